// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic {
    GAP   = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index 0 is the rightmost entry: glyphs F..0 listed left to right.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = seg_decode(hex);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display scanner: one digit lit per scan_clk period, blank gap between digits.
// Optional leading-zero blanking when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    clk_500,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // [0],[1] synchronize scan_clk; [2] holds the previous synced level for edge detect.
  logic [2:0] sync_pipe;
  logic       tick;

  always_ff @(posedge clk_500) begin
    if (reset) begin
      sync_pipe <= '0;
      tick      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], scan_clk};
      tick      <= sync_pipe[1] & ~sync_pipe[2];
    end
  end

  logic [NUM_DIGITS-1:0][3:0] snap;
  logic [NUM_DIGITS-1:0]      dp_snap;
  logic [NUM_DIGITS-1:0][6:0] dig_seg;
  logic [NUM_DIGITS-1:0]      show;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    hex_to_seg7 u_dec (
      .hex (snap[i]),
      .seg (dig_seg[i])
    );
`ifdef SEG7_LZ_BLANK_EN
    // A digit shows if anything at or above it is nonzero or carries a decimal point.
    if (i == 0) begin : g_lsd
      assign show[i] = 1'b1;
    end else begin : g_upper
      assign show[i] = (|snap[NUM_DIGITS-1:i]) | (|dp_snap[NUM_DIGITS-1:i]);
    end
`else
    assign show[i] = 1'b1;
`endif
  end

  scan_state_e       state;
  logic [IDX_W-1:0]  idx;
  logic [GAP_W-1:0]  gap_cnt;

  // Outputs reflect the state held during the previous cycle, so every
  // pin is a flop and the blank window is exactly GAP_CYCLES long.
  always_ff @(posedge clk_500) begin
    if (reset) begin
      state   <= GAP;
      idx     <= '0;
      gap_cnt <= '0;
      snap    <= '0;
      dp_snap <= '0;
      an      <= '1;
      seg     <= SEG_OFF;
      dp      <= 1'b1;
    end else begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
      case (state)
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state   <= DRIVE;
            gap_cnt <= '0;
            // Frame-coherent capture: only refresh when starting digit 0.
            if (idx == '0) begin
              snap    <= data;
              dp_snap <= dp_mask;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (show[idx]) begin
            an[idx] <= 1'b0;
            seg     <= dig_seg[idx];
            dp      <= ~dp_snap[idx];
          end
          if (tick) begin
            state <= GAP;
            idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
          end
        end
        default: state <= GAP;
      endcase
    end
  end

endmodule
